// File: rtl/parking_gate_sensor.sv
// parking_gate_sensor: turns debounced A/B beam activity into entry/exit count pulses, drives the gate and flags bad passages.
module parking_gate_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CAPACITY        = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic [3:0] count,
  output logic       count_up,
  output logic       count_down,
  output logic       gate_open,
  output logic       full,
  output logic       busy,
  output logic       error
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] CAP = 4'(CAPACITY);
  typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLEAR} state_t;
  logic [1:0] w_raw, r_s1, r_s2, r_filt;
  logic [DW-1:0] r_db [2];
  state_t r_state, w_dec, w_nxt;
  logic [TW-1:0] r_tmr;
  logic r_entry_ok, r_up, r_dn, r_err, r_gate, r_busy, r_full;
  logic w_entry_ok, w_fin_in, w_fin_out, w_up, w_dn, w_tmo, w_err, w_active;
  assign w_raw = {sensor_a, sensor_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_filt <= '0;
      r_db <= '{default: '0};
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) r_db[i] <= '0;
        else if (r_db[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i] <= '0;
          r_filt[i] <= r_s2[i];
        end else r_db[i] <= r_db[i] + 1'b1;
      end
    end
  end
  // Within a path the next state depends only on the current beam pattern.
  always_comb begin
    w_dec = r_state;
    case (r_state)
      IDLE:              w_dec = r_filt == 2'b10 ? IN_A  : r_filt == 2'b01 ? OUT_B  : r_filt == 2'b11 ? WAIT_CLEAR : IDLE;
      IN_A, IN_AB, IN_B: w_dec = r_filt == 2'b10 ? IN_A  : r_filt == 2'b11 ? IN_AB  : r_filt == 2'b01 ? IN_B : IDLE;
      OUT_B, OUT_AB, OUT_A: w_dec = r_filt == 2'b01 ? OUT_B : r_filt == 2'b11 ? OUT_AB : r_filt == 2'b10 ? OUT_A : IDLE;
      WAIT_CLEAR:        w_dec = r_filt == 2'b00 ? IDLE : WAIT_CLEAR;
    endcase
  end
  assign w_active   = !(r_state inside {IDLE, WAIT_CLEAR});
  assign w_tmo      = w_active && w_dec == r_state && r_tmr == TW'(TIMEOUT_CYCLES - 1);
  assign w_nxt      = w_tmo ? WAIT_CLEAR : w_dec;
  assign w_fin_in   = r_state == IN_B && r_filt == 2'b00;
  assign w_fin_out  = r_state == OUT_A && r_filt == 2'b00;
  assign w_up       = w_fin_in && r_entry_ok && count != 4'd15;
  assign w_dn       = w_fin_out && count != 4'd0;
  assign w_err      = w_tmo || (r_state == IDLE && r_filt == 2'b11) || (w_fin_in && !w_up) || (w_fin_out && !w_dn);
  assign w_entry_ok = (r_state == IDLE && w_dec == IN_A) ? !r_full : r_entry_ok;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tmr <= '0;
      r_entry_ok <= 1'b0;
      r_up <= 1'b0;
      r_dn <= 1'b0;
      r_err <= 1'b0;
      r_gate <= 1'b0;
      r_busy <= 1'b0;
      r_full <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tmr <= (w_nxt != r_state || !w_active) ? '0 : r_tmr + 1'b1;
      r_entry_ok <= w_entry_ok;
      r_up <= w_up;
      r_dn <= w_dn;
      r_err <= w_err;
      r_gate <= (w_nxt inside {OUT_B, OUT_AB, OUT_A}) || ((w_nxt inside {IN_A, IN_AB, IN_B}) && w_entry_ok);
      r_busy <= w_nxt != IDLE;
      r_full <= count >= CAP;
    end
  end
  assign count_up   = r_up;
  assign count_down = r_dn;
  assign error      = r_err;
  assign gate_open  = r_gate;
  assign busy       = r_busy;
  assign full       = r_full;
endmodule

// File: tb/tb_parking_gate_sensor.sv
// tb_parking_gate_sensor: directed and random passages; pulse events scored against a passage-level model.
module tb_parking_gate_sensor;
  localparam int EV_UP = 0, EV_DN = 1, EV_ERR = 2;
  logic clk = 1'b0, rst = 1'b1, sensor_a = 1'b0, sensor_b = 1'b0;
  logic [3:0] count = 4'd0;
  logic count_up, count_down, gate_open, full, busy, error;
  int checks = 0, errors = 0;
  int exp_q[$];
  int c, n, cur, g;
  logic [1:0] ph [4];
  always #5 clk = ~clk;
  parking_gate_sensor dut (
    .clk(clk), .rst(rst), .sensor_a(sensor_a), .sensor_b(sensor_b), .count(count),
    .count_up(count_up), .count_down(count_down), .gate_open(gate_open),
    .full(full), .busy(busy), .error(error)
  );
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic hold(logic [1:0] ab, int cyc);
    sensor_a = ab[1];
    sensor_b = ab[0];
    repeat (cyc) @(negedge clk);
  endtask
  task automatic phase(string name, logic [1:0] ab, int cyc, int eg, int eb);
    hold(ab, cyc);
    chk({name, "_gate"}, gate_open, eg);
    chk({name, "_busy"}, busy, eb);
  endtask
  task automatic chk_zero(string name);
    chk({name, "_up"}, count_up, 0);
    chk({name, "_dn"}, count_down, 0);
    chk({name, "_gate"}, gate_open, 0);
    chk({name, "_full"}, full, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_err"}, error, 0);
  endtask
  always @(negedge clk) begin
    int obs;
    if (!rst && (count_up || count_down || error)) begin
      obs = count_up ? EV_UP : count_down ? EV_DN : EV_ERR;
      chk("one_pulse", int'(count_up) + int'(count_down) + int'(error), 1);
      if (exp_q.size() == 0) chk("unexpected_event", obs, -1);
      else chk("event", obs, exp_q.pop_front());
    end
  end
  initial begin
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    count = 4'd3;
    hold(2'b00, 10);
    exp_q.push_back(EV_UP);
    phase("entry_a", 2'b10, 10, 1, 1);
    phase("entry_ab", 2'b11, 10, 1, 1);
    phase("entry_b", 2'b01, 10, 1, 1);
    phase("entry_clr", 2'b00, 10, 0, 0);
    exp_q.push_back(EV_DN);
    phase("exit_b", 2'b01, 10, 1, 1);
    phase("exit_ab", 2'b11, 10, 1, 1);
    phase("exit_a", 2'b10, 10, 1, 1);
    phase("exit_clr", 2'b00, 10, 0, 0);
    phase("abort_a", 2'b10, 10, 1, 1);
    phase("abort_clr", 2'b00, 10, 0, 0);
    hold(2'b01, 2);
    phase("spike", 2'b00, 10, 0, 0);
    count = 4'd15;
    hold(2'b00, 5);
    chk("full_set", full, 1);
    exp_q.push_back(EV_ERR);
    phase("full_a", 2'b10, 10, 0, 1);
    phase("full_ab", 2'b11, 10, 0, 1);
    phase("full_b", 2'b01, 10, 0, 1);
    phase("full_clr", 2'b00, 10, 0, 0);
    count = 4'd0;
    hold(2'b00, 5);
    chk("full_clear", full, 0);
    exp_q.push_back(EV_ERR);
    phase("empty_b", 2'b01, 10, 1, 1);
    phase("empty_ab", 2'b11, 10, 1, 1);
    phase("empty_a", 2'b10, 10, 1, 1);
    phase("empty_clr", 2'b00, 10, 0, 0);
    count = 4'd3;
    hold(2'b00, 5);
    exp_q.push_back(EV_ERR);
    phase("tmo_early", 2'b10, 1000, 1, 1);
    chk("tmo_pending", exp_q.size(), 1);
    phase("tmo_wait", 2'b10, 100, 0, 1);
    chk("tmo_fired", exp_q.size(), 0);
    phase("tmo_clr", 2'b00, 12, 0, 0);
    phase("rst_a", 2'b10, 10, 1, 1);
    phase("rst_ab", 2'b11, 10, 1, 1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hold(2'b00, 10);
    exp_q.push_back(EV_UP);
    phase("post_a", 2'b10, 10, 1, 1);
    phase("post_b", 2'b01, 10, 1, 1);
    phase("post_clr", 2'b00, 12, 0, 0);
    for (int p = 0; p < 40; p++) begin
      c = $urandom_range(0, 15);
      count = 4'(c);
      hold(2'b00, 8);
      chk("rnd_full", full, int'(c >= 15));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        do cur = $urandom_range(1, 3); while (i > 0 && 2'(cur) == ph[i-1]);
        ph[i] = 2'(cur);
      end
      g = ph[0] == 2'b10 ? int'(c < 15) : ph[0] == 2'b01 ? 1 : 0;
      if (ph[0] == 2'b11) exp_q.push_back(EV_ERR);
      else if (ph[0] == 2'b10 && ph[n-1] == 2'b01) exp_q.push_back((c < 15 && c != 15) ? EV_UP : EV_ERR);
      else if (ph[0] == 2'b01 && ph[n-1] == 2'b10) exp_q.push_back(c != 0 ? EV_DN : EV_ERR);
      for (int i = 0; i < n; i++) phase("rnd_ph", ph[i], $urandom_range(8, 20), g, 1);
      phase("rnd_clr", 2'b00, 12, 0, 0);
    end
    hold(2'b00, 20);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_gate_sensor.md
Name: parking_gate_sensor

Overview:
Gate-side producer for the occupancy counter. Watches two beam sensors at the lane: A is outside and B is inside. It decodes full vehicle passages into single-cycle count_up (entry) or count_down (exit) pulses that drive the counter's inputs directly. It also drives the barrier (gate_open) and flags malformed or aborted passages.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synced samples required before the filtered sensor value changes (min 1)
TIMEOUT_CYCLES, 1000, max cycles allowed in any non-IDLE passage state
CAPACITY, 15, occupancy at or above which entry is refused (<= 15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
sensor_a  input  1  raw outside beam, 1 = blocked, asynchronous to clk
sensor_b  input  1  raw inside beam, 1 = blocked, asynchronous to clk
count  input  4  current occupancy from the counter
count_up  output  1  one-cycle entry pulse
count_down  output  1  one-cycle exit pulse
gate_open  output  1  barrier raise command
full  output  1  registered (count >= CAPACITY)
busy  output  1  FSM not in IDLE
error  output  1  one-cycle fault pulse

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - Sync and debounce registers 0.
  - Filtered A and B = 0.
  - FSM = IDLE; timeout counter = 0.
- Input path:
  - Each sensor passes through a 2-FF synchronizer, then a debouncer.
  - The filtered value takes the synced value only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current filtered value.
  - Any mismatch restarts the run.
- FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLEAR. Below, (a,b) = filtered values.
- IDLE:
  - (1,0) -> IN_A; latch entry_ok = !full.
  - (0,1) -> OUT_B.
  - (1,1) -> WAIT_CLEAR with error pulse.
- Entry path:
  - IN_A: (1,1) -> IN_AB; (0,0) -> IDLE (abort, no pulse); (0,1) -> IN_B.
  - IN_AB: (0,1) -> IN_B; (1,0) -> IN_A; (0,0) -> IDLE, abort.
  - IN_B: (0,0) -> IDLE with count_up; (1,1) -> IN_AB; (1,0) -> IN_A.
- Exit path: mirror of entry with A and B swapped (OUT_B -> OUT_AB -> OUT_A). Completion from OUT_A on (0,0) -> IDLE with count_down.
- Pulses:
  - count_up and count_down are registered and high exactly one cycle, in the cycle after the transition is decided.
  - They are never both high.
  - count_up is suppressed if entry_ok=0 or count==15; in that case error pulses instead.
  - count_down is suppressed if count==0; in that case error pulses instead.
- Timeout:
  - The counter clears on every state change and increments while the FSM is not in IDLE or WAIT_CLEAR.
  - Reaching TIMEOUT_CYCLES -> error pulse and WAIT_CLEAR.
- WAIT_CLEAR: stays until (0,0), then -> IDLE. No count pulses.
- gate_open (registered):
  - 1 in all OUT_* states.
  - 1 in IN_* states only when entry_ok=1.
  - 0 otherwise.
- busy = (state != IDLE), registered.
- full is recomputed every cycle from count. entry_ok does not change mid-passage.
- Latency: raw edge to filtered edge = 2 + DEBOUNCE_CYCLES cycles. Final filtered clear to count pulse = 1 cycle.
- Reset mid-passage: immediate return to reset values. No pulse is emitted for the interrupted passage.

Test Plan:
- Entry, count=3: A=1; then A=B=1; then A=0,B=1; then both 0, each held 10 cycles -> exactly one count_up pulse, no error, gate_open=1 from IN_A through IN_B.
- Exit, count=3: B, then AB, then A, then clear -> one count_down pulse; count_up stays 0.
- Abort and glitch: A=1 then A=0 (no B) -> no pulses, busy returns 0. A 2-cycle spike on B with DEBOUNCE_CYCLES=4 -> filtered B never changes.
- Full, CAPACITY=15 and count=15: entry sequence -> gate_open stays 0, no count_up, one error pulse at completion. Exit at count=0 -> no count_down, one error pulse.
- Timeout, TIMEOUT_CYCLES=1000: hold A=1 for 1100 cycles -> error pulse at cycle 1000 of IN_A, then WAIT_CLEAR; releasing A returns to IDLE with no pulse.
- Reset mid-passage: assert rst while in IN_AB -> all outputs 0 immediately. After release, a fresh entry yields one count_up.
